// File: rtl/sha_apb_pkg.sv
// Shared constants for the hardware SHA-256 APB initiator: peripheral register
// offsets, core address map, RW codes, sequencer states and the per-step request table.
package sha_apb_pkg;

    localparam logic [7:0] OFF_ADDRESS = 8'h10;
    localparam logic [7:0] OFF_MESSAGE = 8'h14;
    localparam logic [7:0] OFF_RW      = 8'h18;
    localparam logic [7:0] OFF_DIGEST  = 8'h1C;

    localparam logic [7:0] CORE_CTRL   = 8'h08;
    localparam logic [7:0] CORE_STATUS = 8'h09;
    localparam logic [7:0] CORE_BLOCK  = 8'h10;
    localparam logic [7:0] CORE_DIGEST = 8'h20;

    localparam logic [31:0] RW_IDLE   = 32'h0000_0000;
    localparam logic [31:0] RW_READ   = 32'h0000_0002;
    localparam logic [31:0] RW_WRITE  = 32'h0000_0003;
    localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
    localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CTRL = 3'd2,
        ST_POLL = 3'd3,
        ST_READ = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    typedef struct packed {
        logic [7:0]  offset;
        logic [31:0] wdata;
        logic        write;
    } xfer_req_t;

    // Maps one step of a core write (CW) or core read (CR) onto a single APB transfer.
    function automatic xfer_req_t step_req(input logic is_read, input logic [1:0] step,
                                           input logic [7:0] core_addr, input logic [31:0] data);
        xfer_req_t r;
        r.offset = OFF_ADDRESS;
        r.wdata  = {24'h00_0000, core_addr};
        r.write  = 1'b1;
        case (step)
            2'd0: r.offset = OFF_ADDRESS;
            2'd1: begin
                r.offset = is_read ? OFF_RW : OFF_MESSAGE;
                r.wdata  = is_read ? RW_READ : data;
            end
            2'd2: begin
                r.offset = OFF_RW;
                r.wdata  = is_read ? RW_IDLE : RW_WRITE;
            end
            default: begin
                r.offset = is_read ? OFF_DIGEST : OFF_RW;
                r.wdata  = RW_IDLE;
                r.write  = !is_read;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha_apb_xfer.sv
// Single APB transfer engine: SETUP then ACCESS until PREADY, with a new transfer
// allowed to start straight out of the PREADY cycle.
module sha_apb_xfer
    import sha_apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      launch_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]               wdata_i,
    input  logic                      write_i,
    output logic                      done_o,
    output logic [31:0]               rdata_o,
    output logic                      slverr_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;

    assign done_o   = psel_q && penable_q && PREADY;
    assign rdata_o  = PRDATA;
    assign slverr_o = PSLVERR;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

    // Transfer phase sequencing; address/data only change when a transfer is launched.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (launch_i) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = write_i;
            paddr_d   = addr_i;
            pwdata_d  = wdata_i;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (done_o) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end else begin
            psel_d    = psel_q;
        end
    end

    // Bus register bank.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= 32'h0000_0000;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

endmodule

// File: rtl/sha_apb_master.sv
// Hardware APB initiator for the SHA-256 peripheral: loads one block, kicks the core,
// polls status and reads back the digest without CPU help.
module sha_apb_master
    import sha_apb_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        POLL_LIMIT     = 1024
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      start_i,
    input  logic                      first_i,
    input  logic [511:0]              block_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [255:0]              digest_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int              PCW       = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0]  POLL_LAST = PCW'(POLL_LIMIT - 1);

    state_e         state_q, state_d;
    logic [1:0]     step_q, step_d;
    logic [3:0]     idx_q, idx_d;
    logic [PCW-1:0] poll_q, poll_d;
    logic           first_q, first_d;
    logic [511:0]   block_q, block_d;
    logic [255:0]   shadow_q, shadow_d;
    logic [255:0]   digest_q, digest_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic                      launch_s;
    logic                      err_s;
    logic                      is_read_s;
    logic [7:0]                core_addr_s;
    logic [31:0]               core_data_s;
    xfer_req_t                 req_s;
    logic [APB_ADDR_WIDTH-1:0] xfer_addr_s;
    logic                      xfer_done_s;
    logic [31:0]               xfer_rdata_s;
    logic                      xfer_slverr_s;

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign error_o  = error_q;
    assign digest_o = digest_q;

    // Sequencer: advances step/word/poll counters on each completed transfer and
    // launches the next one in the same cycle, so transfers run back to back.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        idx_d    = idx_q;
        poll_d   = poll_q;
        first_d  = first_q;
        block_d  = block_q;
        shadow_d = shadow_q;
        launch_s = 1'b0;
        err_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    first_d  = first_i;
                    block_d  = block_i;
                    step_d   = 2'd0;
                    idx_d    = 4'd0;
                    poll_d   = '0;
                    launch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD, ST_CTRL, ST_POLL, ST_READ: begin
                if (!xfer_done_s) begin
                    state_d = state_q;
                end else if (xfer_slverr_s) begin
                    state_d = ST_DONE;
                    err_s   = 1'b1;
                end else if (step_q != 2'd3) begin
                    step_d   = step_q + 2'd1;
                    launch_s = 1'b1;
                end else begin
                    step_d   = 2'd0;
                    launch_s = 1'b1;
                    case (state_q)
                        ST_LOAD: begin
                            if (idx_q == 4'd15) begin
                                state_d = ST_CTRL;
                                idx_d   = 4'd0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        ST_CTRL: begin
                            state_d = ST_POLL;
                            poll_d  = '0;
                        end
                        ST_POLL: begin
                            if (xfer_rdata_s[0]) begin
                                state_d = ST_READ;
                                idx_d   = 4'd0;
                            end else if (poll_q == POLL_LAST) begin
                                state_d  = ST_DONE;
                                err_s    = 1'b1;
                                launch_s = 1'b0;
                            end else begin
                                poll_d = poll_q + PCW'(1'b1);
                            end
                        end
                        ST_READ: begin
                            shadow_d[{3'd7 - idx_q[2:0], 5'd0} +: 32] = xfer_rdata_s;
                            if (idx_q == 4'd7) begin
                                state_d  = ST_DONE;
                                launch_s = 1'b0;
                            end else begin
                                idx_d = idx_q + 4'd1;
                            end
                        end
                        default: begin
                            state_d  = ST_IDLE;
                            launch_s = 1'b0;
                        end
                    endcase
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request for the transfer being launched, derived from the next-state counters.
    always_comb begin
        core_addr_s = 8'h00;
        core_data_s = 32'h0000_0000;
        is_read_s   = (state_d == ST_POLL) || (state_d == ST_READ);
        case (state_d)
            ST_LOAD: begin
                core_addr_s = CORE_BLOCK + {4'h0, idx_d};
                core_data_s = block_d[{4'd15 - idx_d, 5'd0} +: 32];
            end
            ST_CTRL: core_data_s = first_d ? CTRL_INIT : CTRL_NEXT;
            ST_POLL: core_addr_s = CORE_STATUS;
            ST_READ: core_addr_s = CORE_DIGEST + {5'h00, idx_d[2:0]};
            default: core_addr_s = 8'h00;
        endcase
        if (state_d == ST_CTRL) begin
            core_addr_s = CORE_CTRL;
        end else begin
            core_addr_s = core_addr_s;
        end
        req_s       = step_req(is_read_s, step_d, core_addr_s, core_data_s);
        xfer_addr_s = BASE_ADDR + APB_ADDR_WIDTH'(req_s.offset);
    end

    // Client-side status; digest only moves on an error-free completion.
    always_comb begin
        busy_d   = (state_d == ST_LOAD) || (state_d == ST_CTRL) ||
                   (state_d == ST_POLL) || (state_d == ST_READ);
        done_d   = (state_d == ST_DONE);
        error_d  = done_d && err_s;
        if (done_d && !err_s) begin
            digest_d = shadow_d;
        end else begin
            digest_d = digest_q;
        end
    end

    // State and output registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            step_q   <= 2'd0;
            idx_q    <= 4'd0;
            poll_q   <= '0;
            first_q  <= 1'b0;
            block_q  <= '0;
            shadow_q <= '0;
            digest_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            poll_q   <= poll_d;
            first_q  <= first_d;
            block_q  <= block_d;
            shadow_q <= shadow_d;
            digest_q <= digest_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    sha_apb_xfer #(
        .APB_ADDR_WIDTH(APB_ADDR_WIDTH)
    ) u_xfer (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .launch_i(launch_s),
        .addr_i  (xfer_addr_s),
        .wdata_i (req_s.wdata),
        .write_i (req_s.write),
        .done_o  (xfer_done_s),
        .rdata_o (xfer_rdata_s),
        .slverr_o(xfer_slverr_s),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

endmodule

// File: tb/tb_sha_apb_master.sv
// Bench for sha_apb_master: SHA-256 peripheral model on the APB side, scoreboard of
// expected completions on the client side.
module tb_sha_apb_master;

    logic         HCLK;
    logic         HRESET;
    logic         start_i;
    logic         first_i;
    logic [511:0] block_i;
    logic         busy_o, done_o, error_o;
    logic [255:0] digest_o;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE, PSEL, PENABLE;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;

    sha_apb_master #(
        .APB_ADDR_WIDTH(12),
        .BASE_ADDR     (12'h000),
        .POLL_LIMIT    (4)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .first_i(first_i),
        .block_i(block_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .digest_o(digest_o), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [511:0] put_word(input logic [511:0] blk, input logic [3:0] idx,
                                              input logic [31:0] d);
        logic [511:0] r;
        r = blk;
        r[(15 - idx) * 32 +: 32] = d;
        return r;
    endfunction

    // Peripheral model: PREADY on the second ACCESS cycle, indirect core access via RW.
    logic [11:0]  log_addr [1024];
    logic [31:0]  log_data [1024];
    logic         log_wr   [1024];
    int           xfer_total = 0;
    int           poll_total = 0;
    int           pend       = 0;
    int           err_at     = 0;
    bit           never_ready = 1'b0;
    logic [7:0]   m_addr  = 8'h00;
    logic [31:0]  m_msg   = 32'h0;
    logic [31:0]  m_rd    = 32'h0;
    logic [31:0]  ctrl_last = 32'h0;
    logic [511:0] m_block = '0;
    logic [255:0] h_m     = '0;

    assign PRDATA  = m_rd;
    assign PSLVERR = (err_at != 0) && (xfer_total + 1 == err_at) && PSEL && PENABLE && PREADY;

    always @(posedge HCLK) begin
        if (HRESET) PREADY <= 1'b0;
        else        PREADY <= PSEL && PENABLE && !PREADY;
        if (!HRESET && PSEL && PENABLE && PREADY) begin
            log_addr[xfer_total % 1024] <= PADDR;
            log_data[xfer_total % 1024] <= PWDATA;
            log_wr[xfer_total % 1024]   <= PWRITE;
            xfer_total <= xfer_total + 1;
            if (PWRITE) begin
                if (PADDR == 12'h010) m_addr <= PWDATA[7:0];
                else if (PADDR == 12'h014) m_msg <= PWDATA;
                else if (PADDR == 12'h018 && PWDATA[1:0] == 2'b11) begin
                    if (m_addr >= 8'h10 && m_addr <= 8'h1F) m_block <= put_word(m_block, m_addr[3:0], m_msg);
                    else if (m_addr == 8'h08) begin
                        ctrl_last <= m_msg;
                        pend      <= 2;
                        if (m_msg[0])      h_m <= sha_compress(SHA_IV, m_block);
                        else if (m_msg[1]) h_m <= sha_compress(h_m, m_block);
                    end
                end else if (PADDR == 12'h018 && PWDATA[1:0] == 2'b10) begin
                    if (m_addr == 8'h09) begin
                        m_rd       <= {31'd0, !never_ready && pend == 0};
                        pend       <= (pend > 0) ? pend - 1 : 0;
                        poll_total <= poll_total + 1;
                    end else begin
                        m_rd <= h_m[(7 - m_addr[2:0]) * 32 +: 32];
                    end
                end
            end
        end
    end

    typedef struct { logic err; logic [255:0] dig; } exp_t;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one block, pushes its expected completion and scores done_o against it.
    task automatic run_block(input string tag, input logic [511:0] blk, input logic first,
                             input logic exp_err, input logic [255:0] exp_dig,
                             input bit mon, input bit poke);
        int   base, cyc, load_len;
        bit   seen;
        exp_t e;
        logic [11:0] ea [4];
        logic [31:0] ed [4];
        base = xfer_total;
        @(negedge HCLK);
        block_i = blk; first_i = first; start_i = 1'b1;
        sb_q.push_back('{exp_err, exp_dig});
        @(negedge HCLK);
        start_i = 1'b0; block_i = ~blk;
        check({tag, "_busy_n1"}, busy_o, 1'b1);
        if (mon) begin
            check({tag, "_psel_n1"}, PSEL, 1'b1);
            check({tag, "_penable_n1"}, PENABLE, 1'b0);
        end
        cyc = 1; seen = 1'b0; load_len = -1;
        while (!seen && cyc < 4000) begin
            if (load_len < 0 && PSEL && !PENABLE && PWRITE && PADDR == 12'h010 && PWDATA == 32'h8)
                load_len = cyc - 1;
            if (poke) start_i = (cyc == 50);
            if (done_o) seen = 1'b1;
            else begin
                @(negedge HCLK);
                cyc++;
            end
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 1'b1, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_error"}, error_o, e.err);
                check({tag, "_digest"}, digest_o, e.dig);
            end
        end
        @(negedge HCLK);
        check({tag, "_done_pulse"}, done_o, 1'b0);
        check({tag, "_busy_after"}, busy_o, 1'b0);
        check({tag, "_digest_hold"}, digest_o, exp_dig);
        if (mon) begin
            check({tag, "_load_len"}, load_len, 192);
            ea = '{12'h010, 12'h014, 12'h018, 12'h018};
            ed = '{32'h10, blk[511:480], 32'h3, 32'h0};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_cw%0d_addr", tag, k), log_addr[(base + k) % 1024], ea[k]);
                check($sformatf("%s_cw%0d_data", tag, k), log_data[(base + k) % 1024], ed[k]);
                check($sformatf("%s_cw%0d_wr", tag, k), log_wr[(base + k) % 1024], 1'b1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [511:0] blk_a, blk_b;
        logic [255:0] dig_a, dig_b, committed;
        int base, pbase;
        bit any;
        HRESET = 1'b1; start_i = 1'b0; first_i = 1'b0; block_i = '0;
        for (int i = 0; i < 16; i++) begin
            blk_a[511 - 32*i -: 32] = 32'hdeadbeef ^ (32'h01010101 * i);
            blk_b[511 - 32*i -: 32] = 32'h0badf00d + (32'h11111111 * i);
        end
        repeat (3) @(negedge HCLK);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 12'h000);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_done", done_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_digest", digest_o, 256'h0);
        HRESET = 1'b0;

        run_block("abc", ABC_BLK, 1'b1, 1'b0, ABC_DIG, 1'b1, 1'b0);

        dig_a = sha_compress(SHA_IV, blk_a);
        run_block("blk_a", blk_a, 1'b1, 1'b0, dig_a, 1'b0, 1'b1);
        check("blk_a_ctrl", ctrl_last, 32'h1);
        any = 1'b0;
        repeat (20) begin
            @(negedge HCLK);
            any = any | busy_o | done_o | PSEL;
        end
        check("busy_start_ignored", any, 1'b0);

        dig_b = sha_compress(dig_a, blk_b);
        run_block("blk_b", blk_b, 1'b0, 1'b0, dig_b, 1'b0, 1'b0);
        check("blk_b_ctrl", ctrl_last, 32'h2);
        committed = dig_b;

        base = xfer_total;
        err_at = xfer_total + 5;
        run_block("slverr", blk_a, 1'b1, 1'b1, committed, 1'b0, 1'b0);
        check("slverr_xfers", xfer_total - base, 5);
        check("slverr_psel", PSEL, 1'b0);
        err_at = 0;

        pbase = poll_total;
        never_ready = 1'b1;
        run_block("timeout", blk_b, 1'b1, 1'b1, committed, 1'b0, 1'b0);
        check("timeout_polls", poll_total - pbase, 4);
        never_ready = 1'b0;

        @(negedge HCLK);
        block_i = blk_a; first_i = 1'b1; start_i = 1'b1;
        @(negedge HCLK);
        start_i = 1'b0;
        repeat (40) @(negedge HCLK);
        check("mid_load_busy", busy_o, 1'b1);
        HRESET = 1'b1;
        @(negedge HCLK);
        check("hrst_psel", PSEL, 1'b0);
        check("hrst_penable", PENABLE, 1'b0);
        check("hrst_pwrite", PWRITE, 1'b0);
        check("hrst_paddr", PADDR, 12'h000);
        check("hrst_pwdata", PWDATA, 32'h0);
        check("hrst_busy", busy_o, 1'b0);
        check("hrst_done", done_o, 1'b0);
        check("hrst_error", error_o, 1'b0);
        check("hrst_digest", digest_o, 256'h0);
        @(negedge HCLK);
        HRESET = 1'b0;

        run_block("after_rst", ABC_BLK, 1'b1, 1'b0, ABC_DIG, 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
